cdce_readback: RTL and testbench
================================

# cdce_readback

Register readback engine for the CDCE clock synthesizer's serial port. It is the receive counterpart of the configuration write path. On request it issues a read command frame for one CDCE register, then runs a second frame that shifts the register contents in from `miso` and presents them as a parallel word. It sits beside the configuration controller and uses the same `cs_n`/`mosi`/`miso` pins, with `clk` acting as the serial clock. Arbitration between this block and the configuration path happens outside the block.

## Interface
Parameters:
- `WORD_WIDTH`, default 32: bits per serial frame, in both the command frame and the readout frame.
- `GAP_CYCLES`, default 4: cycles `cs_n` is held high between the command frame and the readout frame. Legal range is 1 to 255.

Ports:
- `clk` input, 1 bit: the single clock for the block. It is also the serial clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request a readback. Sampled only in IDLE.
- `reg_addr` input, 4 bits: CDCE register number to read. Latched on the edge where `start` is accepted.
- `miso` input, 1 bit: serial data from the CDCE.
- `cs_n` output, 1 bit: chip select, active low.
- `mosi` output, 1 bit: serial data to the CDCE.
- `busy` output, 1 bit: high in every state except IDLE.
- `read_data` output, `WORD_WIDTH` bits: last captured register word.
- `read_valid` output, 1 bit: one-cycle pulse when `read_data` has just been updated.

## Operation
Command word format:
- The command word is `{zeros, reg_addr, 4'hE}`, zero-extended to `WORD_WIDTH`.
- Bits are sent LSB first.
- Bit i is driven on `mosi` during cycle i of the frame, where cycle 0 is the first cycle with `cs_n` low.

Readout capture:
- During cycle i of the readout frame, `miso` is sampled at the rising edge that ends that cycle.
- The sampled bit is stored into bit i of the shift register (LSB first).

State machine:
- IDLE: `cs_n`=1, `mosi`=0, `busy`=0.
  - `start`=1 latches `reg_addr` and the command word and moves to CMD.
- CMD: `cs_n`=0 for `WORD_WIDTH` cycles, `mosi` carries the current command bit. Then moves to GAP.
- GAP: `cs_n`=1, `mosi`=0 for `GAP_CYCLES` cycles. Then moves to READ.
- READ: `cs_n`=0, `mosi`=0 for `WORD_WIDTH` cycles while `miso` is captured.
  - On the edge that captures the last bit, `read_data` loads the full word and the state moves to DONE.
- DONE: one cycle with `cs_n`=1, `read_valid`=1, `busy`=1. Then moves to IDLE.

Counters:
- One bit counter, wide enough for `WORD_WIDTH`, shared by CMD and READ.
- One gap counter.
- Both clear on every state entry.

Boundary conditions:
- `start` while `busy`=1 is ignored, including in the DONE cycle. It is not queued.
- `start` held high continuously: the next command frame starts on the edge after the IDLE cycle. That gives at least 2 cycles of `cs_n` high (DONE + IDLE) between the readout frame and the next command frame.
- `reg_addr` values 9 to 15 are sent unchanged; the block does no range checking.
- `miso` is ignored outside READ and may be X there.
- `read_data` holds its value until the next DONE. An aborted read never updates it.

Reset:
- Reset values: `cs_n`=1, `mosi`=0, `busy`=0, `read_valid`=0, `read_data`=0, state IDLE, counters 0.
- Reset in any state, mid-frame included, takes effect at the next edge. The frame is abandoned and the reset values above apply.

## Timing
Let edge E0 be the edge that accepts `start`.
- Command frame: `cs_n` is low during the cycles after edges E0 through E(W-1), with W = `WORD_WIDTH`. Bit 0 is on `mosi` in the cycle after E0.
- Gap: `cs_n` is high for exactly `GAP_CYCLES` cycles, starting after E(W).
- Readout frame: `cs_n` is low for W cycles, starting after E(W+G), with G = `GAP_CYCLES`.
- Completion: the final `miso` bit is captured at E(2W+G). `read_valid`=1 and the new `read_data` appear in the cycle after E(2W+G).
- Latency from start to `read_valid` is 2W+G cycles after E0: 68 cycles with the default parameters.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset values: assert `reset` for 3 cycles → `cs_n`=1, `mosi`=0, `busy`=0, `read_valid`=0, `read_data`=0.
- Basic read: pulse `start` with `reg_addr`=3 and a device model that returns 32'hA5C3_0F81.
  - `mosi` command frame decodes to 32'h0000_003E.
  - `cs_n` goes high for exactly 4 cycles between frames.
  - `read_data`=32'hA5C3_0F81 with a single `read_valid` pulse at E0+68.
- Busy rejection: pulse `start` with `reg_addr`=7 during CMD, and again in the DONE cycle → only the original transaction runs, and only one `read_valid` pulse appears.
- Reset mid-READ: assert `reset` at readout bit 10 → `cs_n`=1 on the next cycle, `read_data`=0, and no `read_valid` pulse.
- Back-to-back reads: hold `start`=1 with `reg_addr` 0, then 8 → two complete transactions, `cs_n` high for 2 cycles between them, and correct data for each.
- Gap parameter: instantiate with `GAP_CYCLES`=1 → `cs_n` is high for 1 cycle between frames and `read_valid` occurs at E0+65.

Source files
------------

// File: rtl/cdce_readback.sv
// cdce_readback: CDCE register readback engine; sends a read command frame, then shifts the register word in from miso.
module cdce_readback #(
   parameter int WORD_WIDTH = 32,
   parameter int GAP_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            reg_addr,
   input  logic                  miso,
   output logic                  cs_n,
   output logic                  mosi,
   output logic                  busy,
   output logic [WORD_WIDTH-1:0] read_data,
   output logic                  read_valid
);
   localparam int CW = $clog2(WORD_WIDTH);
   typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0] gap, gap_n;
   logic [WORD_WIDTH-1:0] cmd, cmd_n, shift, shift_n;
   logic last_bit;
   assign last_bit = cnt == CW'(WORD_WIDTH - 1);
   // cmd shifts right so bit 0 always holds the bit for the coming cycle
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gap_n   = gap;
      cmd_n   = cmd;
      shift_n = shift;
      case (state)
         IDLE: if (start) begin
            state_n = CMD;
            cnt_n   = '0;
            gap_n   = '0;
            cmd_n   = {{(WORD_WIDTH-8){1'b0}}, reg_addr, 4'hE};
         end
         CMD: begin
            cmd_n = cmd >> 1;
            cnt_n = last_bit ? '0 : cnt + 1'b1;
            state_n = last_bit ? GAP : CMD;
            gap_n = '0;
         end
         GAP: begin
            state_n = gap == 8'(GAP_CYCLES - 1) ? READ : GAP;
            gap_n = gap == 8'(GAP_CYCLES - 1) ? '0 : gap + 8'd1;
            cnt_n = '0;
         end
         READ: begin
            shift_n = {miso, shift[WORD_WIDTH-1:1]};
            cnt_n = last_bit ? '0 : cnt + 1'b1;
            state_n = last_bit ? DONE : READ;
         end
         DONE: begin
            state_n = IDLE;
            cnt_n   = '0;
            gap_n   = '0;
         end
         default: state_n = IDLE;
      endcase
   end
   // outputs are registered from the next-state values so they line up with the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         gap        <= '0;
         cmd        <= '0;
         shift      <= '0;
         cs_n       <= 1'b1;
         mosi       <= 1'b0;
         busy       <= 1'b0;
         read_valid <= 1'b0;
         read_data  <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         gap        <= gap_n;
         cmd        <= cmd_n;
         shift      <= shift_n;
         cs_n       <= !(state_n == CMD || state_n == READ);
         mosi       <= state_n == CMD && cmd_n[0];
         busy       <= state_n != IDLE;
         read_valid <= state_n == DONE;
         if (state == READ && last_bit) read_data <= shift_n;
      end
   end
endmodule

// File: tb/tb_cdce_readback.sv
// tb_cdce_readback: randomized bench decoding the serial frames of two cdce_readback instances (gap 4 and gap 1).
module tb_cdce_readback;
   localparam int W = 32;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, start, miso;
   logic [3:0] reg_addr;
   logic cs_n0, mosi0, busy0, rv0, cs_n1, mosi1, busy1, rv1;
   logic [W-1:0] rd0, rd1;
   cdce_readback #(.WORD_WIDTH(W), .GAP_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .start(start), .reg_addr(reg_addr), .miso(miso),
      .cs_n(cs_n0), .mosi(mosi0), .busy(busy0), .read_data(rd0), .read_valid(rv0));
   cdce_readback #(.WORD_WIDTH(W), .GAP_CYCLES(1)) dut_g1 (
      .clk(clk), .reset(reset), .start(start), .reg_addr(reg_addr), .miso(miso),
      .cs_n(cs_n1), .mosi(mosi1), .busy(busy1), .read_data(rd1), .read_valid(rv1));
   bit sel;
   logic cs_n_s, mosi_s, busy_s, rv_s;
   logic [W-1:0] rd_s;
   assign cs_n_s = sel ? cs_n1 : cs_n0;
   assign mosi_s = sel ? mosi1 : mosi0;
   assign busy_s = sel ? busy1 : busy0;
   assign rv_s   = sel ? rv1 : rv0;
   assign rd_s   = sel ? rd1 : rd0;
   int vecs = 0, errs = 0;
   bit start_sched[400];
   bit reset_sched[400];
   logic [3:0] addr_sched[400];
   logic [W-1:0] dev_data[4];
   int n_fr, n_rv, mosi_bad;
   int fr_start[8], fr_len[8], rv_time[8];
   logic [W-1:0] fr_word[8], rv_data[8];
   function automatic logic [W-1:0] cmd_word(input logic [3:0] a);
      return W'(a) * 16 + 14;
   endfunction
   task automatic clear_sched();
      for (int i = 0; i < 400; i++) begin
         start_sched[i] = 1'b0;
         reset_sched[i] = 1'b0;
         addr_sched[i] = 4'h0;
      end
   endtask
   // Watches the selected instance: decodes chip-select frames, plays the device on odd frames, logs read_valid pulses.
   task automatic observe(input int cycles);
      bit prev;
      prev = 1'b1;
      n_fr = 0;
      n_rv = 0;
      mosi_bad = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (!cs_n_s && prev) begin
            if (n_fr < 8) begin
               fr_start[n_fr] = c;
               fr_len[n_fr] = 0;
               fr_word[n_fr] = '0;
            end
            n_fr++;
         end
         miso = 1'bx;
         if (!cs_n_s && n_fr <= 8) begin
            int f;
            f = n_fr - 1;
            if (fr_len[f] < W) fr_word[f][fr_len[f]] = mosi_s;
            if (f % 2 == 1) miso = dev_data[(f / 2) % 4][fr_len[f] % W];
            fr_len[f]++;
         end
         if (cs_n_s && mosi_s !== 1'b0) mosi_bad++;
         if (rv_s === 1'b1) begin
            if (n_rv < 8) begin
               rv_time[n_rv] = c;
               rv_data[n_rv] = rd_s;
            end
            n_rv++;
         end
         prev = cs_n_s;
         start = start_sched[c];
         reg_addr = addr_sched[c];
         reset = reset_sched[c];
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      reg_addr = 4'h0;
      miso = 1'b0;
      sel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vecs++; if (cs_n0 !== 1'b1) begin errs++; $display("FAIL reset_cs_n got %b want 1", cs_n0); end
      vecs++; if (mosi0 !== 1'b0) begin errs++; $display("FAIL reset_mosi got %b want 0", mosi0); end
      vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy0); end
      vecs++; if (rv0 !== 1'b0) begin errs++; $display("FAIL reset_read_valid got %b want 0", rv0); end
      vecs++; if (rd0 !== '0) begin errs++; $display("FAIL reset_read_data got %h want 0", rd0); end
      vecs++; if (cs_n1 !== 1'b1 || rd1 !== '0) begin errs++; $display("FAIL reset_g1 got cs_n=%b rd=%h want 1/0", cs_n1, rd1); end
      reset = 1'b0;
   endtask
   task automatic test_basic_read();
      sel = 1'b0;
      clear_sched();
      dev_data[0] = 32'hA5C3_0F81;
      start = 1'b1;
      reg_addr = 4'd3;
      observe(80);
      vecs++; if (n_fr !== 2) begin errs++; $display("FAIL basic_frames got %0d want 2", n_fr); end
      vecs++; if (fr_word[0] !== 32'h0000_003E) begin errs++; $display("FAIL basic_cmd got %h want 0000003e", fr_word[0]); end
      vecs++; if (fr_start[0] != 0 || fr_len[0] != W) begin errs++; $display("FAIL basic_cmd_frame got start=%0d len=%0d want 0/%0d", fr_start[0], fr_len[0], W); end
      vecs++; if (fr_start[1] - fr_start[0] - fr_len[0] != 4) begin errs++; $display("FAIL basic_gap got %0d want 4", fr_start[1] - fr_start[0] - fr_len[0]); end
      vecs++; if (fr_len[1] != W || fr_word[1] !== '0) begin errs++; $display("FAIL basic_read_frame got len=%0d mosi=%h want %0d/0", fr_len[1], fr_word[1], W); end
      vecs++; if (n_rv != 1 || rv_time[0] != 68) begin errs++; $display("FAIL basic_valid got n=%0d t=%0d want 1/68", n_rv, rv_time[0]); end
      vecs++; if (rv_data[0] !== 32'hA5C3_0F81) begin errs++; $display("FAIL basic_data got %h want a5c30f81", rv_data[0]); end
      vecs++; if (rd_s !== 32'hA5C3_0F81 || busy_s !== 1'b0) begin errs++; $display("FAIL basic_hold got rd=%h busy=%b want a5c30f81/0", rd_s, busy_s); end
      vecs++; if (mosi_bad != 0) begin errs++; $display("FAIL basic_mosi_idle got %0d want 0", mosi_bad); end
   endtask
   task automatic test_busy_reject();
      logic [W-1:0] d;
      sel = 1'b0;
      clear_sched();
      d = $urandom;
      dev_data[0] = d;
      start_sched[5] = 1'b1;
      addr_sched[5] = 4'd7;
      start_sched[68] = 1'b1;
      addr_sched[68] = 4'd7;
      start = 1'b1;
      reg_addr = 4'd3;
      observe(100);
      vecs++; if (n_fr != 2) begin errs++; $display("FAIL busy_frames got %0d want 2", n_fr); end
      vecs++; if (fr_word[0] !== cmd_word(4'd3)) begin errs++; $display("FAIL busy_cmd got %h want %h", fr_word[0], cmd_word(4'd3)); end
      vecs++; if (n_rv != 1 || rv_time[0] != 68) begin errs++; $display("FAIL busy_valid got n=%0d t=%0d want 1/68", n_rv, rv_time[0]); end
      vecs++; if (rv_data[0] !== d) begin errs++; $display("FAIL busy_data got %h want %h", rv_data[0], d); end
   endtask
   task automatic test_reset_mid_read();
      sel = 1'b0;
      clear_sched();
      dev_data[0] = $urandom;
      reset_sched[46] = 1'b1;
      start = 1'b1;
      reg_addr = 4'd5;
      observe(80);
      vecs++; if (n_fr != 2 || fr_len[1] != 11) begin errs++; $display("FAIL abort_frame got n=%0d len=%0d want 2/11", n_fr, fr_len[1]); end
      vecs++; if (n_rv != 0) begin errs++; $display("FAIL abort_valid got %0d pulses want 0", n_rv); end
      vecs++; if (rd_s !== '0 || busy_s !== 1'b0 || cs_n_s !== 1'b1) begin errs++; $display("FAIL abort_state got rd=%h busy=%b cs_n=%b want 0/0/1", rd_s, busy_s, cs_n_s); end
   endtask
   task automatic test_back_to_back();
      logic [W-1:0] d0, d1;
      sel = 1'b0;
      clear_sched();
      d0 = $urandom;
      d1 = $urandom;
      dev_data[0] = d0;
      dev_data[1] = d1;
      for (int c = 0; c < 400; c++) addr_sched[c] = 4'd8;
      for (int c = 0; c < 70; c++) start_sched[c] = 1'b1;
      start = 1'b1;
      reg_addr = 4'd0;
      observe(150);
      vecs++; if (n_fr != 4) begin errs++; $display("FAIL b2b_frames got %0d want 4", n_fr); end
      vecs++; if (fr_word[0] !== cmd_word(4'd0) || fr_word[2] !== cmd_word(4'd8)) begin errs++; $display("FAIL b2b_cmd got %h,%h want %h,%h", fr_word[0], fr_word[2], cmd_word(4'd0), cmd_word(4'd8)); end
      vecs++; if (fr_start[2] - fr_start[1] - fr_len[1] != 2) begin errs++; $display("FAIL b2b_gap got %0d want 2", fr_start[2] - fr_start[1] - fr_len[1]); end
      vecs++; if (n_rv != 2 || rv_time[0] != 68 || rv_time[1] != 138) begin errs++; $display("FAIL b2b_valid got n=%0d t=%0d,%0d want 2/68,138", n_rv, rv_time[0], rv_time[1]); end
      vecs++; if (rv_data[0] !== d0 || rv_data[1] !== d1) begin errs++; $display("FAIL b2b_data got %h,%h want %h,%h", rv_data[0], rv_data[1], d0, d1); end
   endtask
   task automatic test_gap_param();
      logic [W-1:0] d;
      logic [3:0] a;
      sel = 1'b1;
      clear_sched();
      d = $urandom;
      a = 4'($urandom_range(9, 15));
      dev_data[0] = d;
      start = 1'b1;
      reg_addr = a;
      observe(80);
      vecs++; if (n_fr != 2 || fr_start[1] - fr_start[0] - fr_len[0] != 1) begin errs++; $display("FAIL gap1_gap got n=%0d gap=%0d want 2/1", n_fr, fr_start[1] - fr_start[0] - fr_len[0]); end
      vecs++; if (fr_word[0] !== cmd_word(a)) begin errs++; $display("FAIL gap1_cmd got %h want %h", fr_word[0], cmd_word(a)); end
      vecs++; if (n_rv != 1 || rv_time[0] != 65) begin errs++; $display("FAIL gap1_valid got n=%0d t=%0d want 1/65", n_rv, rv_time[0]); end
      vecs++; if (rv_data[0] !== d) begin errs++; $display("FAIL gap1_data got %h want %h", rv_data[0], d); end
   endtask
   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         logic [W-1:0] d;
         logic [3:0] a;
         int g;
         sel = 1'($urandom_range(0, 1));
         g = sel ? 1 : 4;
         clear_sched();
         d = $urandom;
         a = k == 0 ? 4'd15 : 4'($urandom_range(0, 15));
         dev_data[0] = d;
         start = 1'b1;
         reg_addr = a;
         observe(2 * W + g + 6);
         vecs++; if (n_fr != 2 || fr_word[0] !== cmd_word(a)) begin errs++; $display("FAIL rnd%0d_cmd got n=%0d %h want 2/%h", k, n_fr, fr_word[0], cmd_word(a)); end
         vecs++; if (fr_start[1] - fr_start[0] - fr_len[0] != g) begin errs++; $display("FAIL rnd%0d_gap got %0d want %0d", k, fr_start[1] - fr_start[0] - fr_len[0], g); end
         vecs++; if (n_rv != 1 || rv_time[0] != 2 * W + g) begin errs++; $display("FAIL rnd%0d_valid got n=%0d t=%0d want 1/%0d", k, n_rv, rv_time[0], 2 * W + g); end
         vecs++; if (rv_data[0] !== d || rd_s !== d) begin errs++; $display("FAIL rnd%0d_data got %h/%h want %h", k, rv_data[0], rd_s, d); end
      end
   endtask
   initial begin
      test_reset();
      test_basic_read();
      test_busy_reject();
      test_reset_mid_read();
      test_back_to_back();
      test_gap_param();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
